// File: rtl/run_sequencer.sv
// run_sequencer: fetch/execute sequencer for a multi-cycle core.
// Ports: clk_i, rst_ni (async, active-low); start_i run request;
//   decoder inputs halt_i, branch_en_i, condition_branch_i,
//   branch_cond_i, branch_target_i, mem_access_i; outputs pc_o,
//   fetch_en_o, exec_en_o, busy_o, done_o, and cycle_count_o when
//   RUN_SEQUENCER_CYCLE_COUNT_EN is defined (busy-cycle counter).
module run_sequencer #(
  parameter int PC_W     = 10,
  parameter int MEM_WAIT = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            halt_i,
  input  logic            branch_en_i,
  input  logic            condition_branch_i,
  input  logic            branch_cond_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            mem_access_i,
  output logic [PC_W-1:0] pc_o,
  output logic            fetch_en_o,
  output logic            exec_en_o,
  output logic            busy_o,
`ifdef RUN_SEQUENCER_CYCLE_COUNT_EN
  output logic [15:0]     cycle_count_o,
`endif
  output logic            done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEMWAIT,
    S_HALTED
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);
  localparam bit         HAS_WAIT  = (MEM_WAIT != 0);

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [2:0]      wait_q;

  logic            taken;
  logic [PC_W-1:0] pc_d;
  logic            mem_stall;
  logic            accept;

  assign taken = branch_en_i &
                 (~condition_branch_i | branch_cond_i);
  assign pc_d  = taken ? branch_target_i
                       : pc_q + PC_W'(1);

  assign mem_stall = mem_access_i & HAS_WAIT;

  assign accept = start_i &
                  ((state_q == S_IDLE) |
                   (state_q == S_HALTED));

  // The decoder fields come from the instruction register, which
  // is frozen between fetches, so qualifying the commit strobe
  // with them in EXEC cannot glitch within the cycle.
  assign exec_en_o =
    ((state_q == S_EXEC) & ~halt_i & ~mem_stall) |
    ((state_q == S_MEMWAIT) & (wait_q == 3'd1));

  assign fetch_en_o = (state_q == S_FETCH);
  assign busy_o     = (state_q == S_FETCH) |
                      (state_q == S_EXEC) |
                      (state_q == S_MEMWAIT);
  assign done_o     = (state_q == S_HALTED);
  assign pc_o       = pc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (start_i) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
          end
        end
        S_FETCH: begin
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (halt_i) begin
            state_q <= S_HALTED;
          end else if (mem_stall) begin
            state_q <= S_MEMWAIT;
            wait_q  <= WAIT_INIT;
          end else begin
            state_q <= S_FETCH;
            pc_q    <= pc_d;
          end
        end
        S_MEMWAIT: begin
          wait_q <= wait_q - 3'd1;
          if (wait_q == 3'd1) begin
            state_q <= S_FETCH;
            pc_q    <= pc_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RUN_SEQUENCER_CYCLE_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (busy_o && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cycle_count_o = cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed-vector bench for run_sequencer.
// Drives a main instance (PC_W=10, MEM_WAIT=2) and a small one (PC_W=4, MEM_WAIT=0).
module tb_run_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start4;
  logic       halt, br, cbr, bcond, mem;
  logic [9:0] tgt;

  logic [9:0] pc;
  logic       fetch, exec, busy, done;
  logic [3:0] pc4;
  logic       f4, e4, b4, d4;
`ifdef RUN_SEQUENCER_CYCLE_COUNT_EN
  logic [15:0] cc, cc4;
`endif

  int vectors = 0;
  int miscompares = 0;
  int n_exec = 0;

  run_sequencer #(.PC_W(10), .MEM_WAIT(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .halt_i(halt), .branch_en_i(br),
    .condition_branch_i(cbr), .branch_cond_i(bcond),
    .branch_target_i(tgt), .mem_access_i(mem),
    .pc_o(pc), .fetch_en_o(fetch), .exec_en_o(exec),
    .busy_o(busy),
`ifdef RUN_SEQUENCER_CYCLE_COUNT_EN
    .cycle_count_o(cc),
`endif
    .done_o(done)
  );

  run_sequencer #(.PC_W(4), .MEM_WAIT(0)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4),
    .halt_i(halt), .branch_en_i(br),
    .condition_branch_i(cbr), .branch_cond_i(bcond),
    .branch_target_i(tgt[3:0]), .mem_access_i(mem),
    .pc_o(pc4), .fetch_en_o(f4), .exec_en_o(e4),
    .busy_o(b4),
`ifdef RUN_SEQUENCER_CYCLE_COUNT_EN
    .cycle_count_o(cc4),
`endif
    .done_o(d4)
  );

  always @(posedge clk) if (exec) n_exec++;

  typedef struct packed {
    logic s, h, b, c, q, m;
    logic [9:0] t;
    logic [9:0] pc;
    logic f, e, y, d;
  } row_t;

  function automatic row_t mk(int s, int h, int b, int c,
      int q, int m, int t, int p, int f, int e, int y, int d);
    row_t r;
    r.s = 1'(s); r.h = 1'(h); r.b = 1'(b); r.c = 1'(c);
    r.q = 1'(q); r.m = 1'(m); r.t = 10'(t); r.pc = 10'(p);
    r.f = 1'(f); r.e = 1'(e); r.y = 1'(y); r.d = 1'(d);
    return r;
  endfunction

  task automatic apply(input row_t r, input bit to4);
    @(negedge clk);
    start  = to4 ? 1'b0 : r.s;
    start4 = to4 ? r.s : 1'b0;
    halt = r.h; br = r.b; cbr = r.c;
    bcond = r.q; mem = r.m; tgt = r.t;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; start4 = 0; halt = 0;
    br = 0; cbr = 0; bcond = 0; mem = 0; tgt = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({pc, fetch, exec, busy, done} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset main got %h want 0",
               {pc, fetch, exec, busy, done});
    end
    vectors++;
    if ({pc4, f4, e4, b4, d4} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset small got %h want 0",
               {pc4, f4, e4, b4, d4});
    end
`ifdef RUN_SEQUENCER_CYCLE_COUNT_EN
    vectors++;
    if (cc !== 16'd0) begin
      miscompares++;
      $display("FAIL reset count got %0d want 0", cc);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_program;
    row_t v[10];
    v[0] = mk(1,0,0,0,0,0,0, 0,0,0,0,0);
    v[1] = mk(0,0,0,0,0,0,0, 0,1,0,1,0);
    v[2] = mk(0,0,0,0,0,0,0, 0,0,1,1,0);
    v[3] = mk(0,0,0,0,0,0,0, 1,1,0,1,0);
    v[4] = mk(0,0,0,0,0,0,0, 1,0,1,1,0);
    v[5] = mk(0,0,0,0,0,0,0, 2,1,0,1,0);
    v[6] = mk(0,0,0,0,0,0,0, 2,0,1,1,0);
    v[7] = mk(0,0,0,0,0,0,0, 3,1,0,1,0);
    v[8] = mk(0,1,0,0,0,0,0, 3,0,0,1,0);
    v[9] = mk(0,0,0,0,0,0,0, 3,0,0,0,1);
    n_exec = 0;
    for (int i = 0; i < 10; i++) begin
      apply(v[i], 1'b0);
      vectors++;
      if ({pc, fetch, exec, busy, done} !==
          {v[i].pc, v[i].f, v[i].e, v[i].y, v[i].d}) begin
        miscompares++;
        $display("FAIL program[%0d] pc/fe/ex/bz/dn got %0d/%b%b%b%b want %0d/%b%b%b%b",
          i, pc, fetch, exec, busy, done,
          v[i].pc, v[i].f, v[i].e, v[i].y, v[i].d);
      end
    end
    vectors++;
    if (n_exec !== 3) begin
      miscompares++;
      $display("FAIL program exec pulses got %0d want 3", n_exec);
    end
`ifdef RUN_SEQUENCER_CYCLE_COUNT_EN
    vectors++;
    if (cc !== 16'd8) begin
      miscompares++;
      $display("FAIL program count got %0d want 8", cc);
    end
`endif
  endtask

  task automatic test_rerun;
    row_t v[2];
    v[0] = mk(1,0,0,0,0,0,0, 3,0,0,0,1);
    v[1] = mk(0,0,0,0,0,0,0, 0,1,0,1,0);
    for (int i = 0; i < 2; i++) begin
      apply(v[i], 1'b0);
      vectors++;
      if ({pc, fetch, exec, busy, done} !==
          {v[i].pc, v[i].f, v[i].e, v[i].y, v[i].d}) begin
        miscompares++;
        $display("FAIL rerun[%0d] pc/fe/ex/bz/dn got %0d/%b%b%b%b want %0d/%b%b%b%b",
          i, pc, fetch, exec, busy, done,
          v[i].pc, v[i].f, v[i].e, v[i].y, v[i].d);
      end
    end
`ifdef RUN_SEQUENCER_CYCLE_COUNT_EN
    vectors++;
    if (cc !== 16'd0) begin
      miscompares++;
      $display("FAIL rerun count got %0d want 0", cc);
    end
`endif
  endtask

  task automatic test_memwait;
    row_t v[4];
    v[0] = mk(0,0,0,0,0,1,0,  0,0,0,1,0);
    v[1] = mk(1,0,1,0,0,1,55, 0,0,0,1,0);
    v[2] = mk(0,0,0,0,0,1,0,  0,0,1,1,0);
    v[3] = mk(0,0,0,0,0,0,0,  1,1,0,1,0);
    for (int i = 0; i < 4; i++) begin
      apply(v[i], 1'b0);
      vectors++;
      if ({pc, fetch, exec, busy, done} !==
          {v[i].pc, v[i].f, v[i].e, v[i].y, v[i].d}) begin
        miscompares++;
        $display("FAIL memwait[%0d] pc/fe/ex/bz/dn got %0d/%b%b%b%b want %0d/%b%b%b%b",
          i, pc, fetch, exec, busy, done,
          v[i].pc, v[i].f, v[i].e, v[i].y, v[i].d);
      end
    end
  endtask

  task automatic test_branch;
    row_t v[12];
    v[0]  = mk(0,0,1,1,0,0,9,    1,0,1,1,0);
    v[1]  = mk(0,0,0,0,0,0,0,    2,1,0,1,0);
    v[2]  = mk(0,0,1,1,1,0,9,    2,0,1,1,0);
    v[3]  = mk(0,0,0,0,0,0,0,    9,1,0,1,0);
    v[4]  = mk(0,0,1,0,0,0,1023, 9,0,1,1,0);
    v[5]  = mk(0,0,0,0,0,0,0, 1023,1,0,1,0);
    v[6]  = mk(0,0,0,0,1,0,5, 1023,0,1,1,0);
    v[7]  = mk(0,0,0,0,0,0,0,    0,1,0,1,0);
    v[8]  = mk(0,0,0,0,0,0,0,    0,0,1,1,0);
    v[9]  = mk(0,0,0,0,0,0,0,    1,1,0,1,0);
    v[10] = mk(0,1,1,0,0,1,77,   1,0,0,1,0);
    v[11] = mk(0,0,0,0,0,0,0,    1,0,0,0,1);
    for (int i = 0; i < 12; i++) begin
      apply(v[i], 1'b0);
      vectors++;
      if ({pc, fetch, exec, busy, done} !==
          {v[i].pc, v[i].f, v[i].e, v[i].y, v[i].d}) begin
        miscompares++;
        $display("FAIL branch[%0d] pc/fe/ex/bz/dn got %0d/%b%b%b%b want %0d/%b%b%b%b",
          i, pc, fetch, exec, busy, done,
          v[i].pc, v[i].f, v[i].e, v[i].y, v[i].d);
      end
    end
  endtask

  task automatic test_wrap4;
    row_t v[8];
    v[0] = mk(1,0,0,0,0,0,0,  0,0,0,0,0);
    v[1] = mk(0,0,0,0,0,0,0,  0,1,0,1,0);
    v[2] = mk(0,0,1,0,0,0,15, 0,0,1,1,0);
    v[3] = mk(0,0,0,0,0,0,0, 15,1,0,1,0);
    v[4] = mk(0,0,0,0,0,1,0, 15,0,1,1,0);
    v[5] = mk(0,0,0,0,0,0,0,  0,1,0,1,0);
    v[6] = mk(0,1,0,0,0,0,0,  0,0,0,1,0);
    v[7] = mk(0,0,0,0,0,0,0,  0,0,0,0,1);
    for (int i = 0; i < 8; i++) begin
      apply(v[i], 1'b1);
      vectors++;
      if ({pc4, f4, e4, b4, d4} !==
          {v[i].pc[3:0], v[i].f, v[i].e, v[i].y, v[i].d}) begin
        miscompares++;
        $display("FAIL wrap4[%0d] pc/fe/ex/bz/dn got %0d/%b%b%b%b want %0d/%b%b%b%b",
          i, pc4, f4, e4, b4, d4,
          v[i].pc[3:0], v[i].f, v[i].e, v[i].y, v[i].d);
      end
    end
  endtask

  task automatic test_reset_mid;
    row_t v[4];
    row_t w[4];
    int   n0;
    v[0] = mk(1,0,0,0,0,0,0, 1,0,0,0,1);
    v[1] = mk(0,0,0,0,0,0,0, 0,1,0,1,0);
    v[2] = mk(0,0,0,0,0,1,0, 0,0,0,1,0);
    v[3] = mk(1,0,0,0,0,1,0, 0,0,0,1,0);
    for (int i = 0; i < 4; i++) begin
      apply(v[i], 1'b0);
      vectors++;
      if ({pc, fetch, exec, busy, done} !==
          {v[i].pc, v[i].f, v[i].e, v[i].y, v[i].d}) begin
        miscompares++;
        $display("FAIL resetmid[%0d] pc/fe/ex/bz/dn got %0d/%b%b%b%b want %0d/%b%b%b%b",
          i, pc, fetch, exec, busy, done,
          v[i].pc, v[i].f, v[i].e, v[i].y, v[i].d);
      end
    end
    @(negedge clk);
    start = 1'b0;
    n0 = n_exec;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({pc, fetch, exec, busy, done} !== 14'd0) begin
      miscompares++;
      $display("FAIL resetmid async got %h want 0",
               {pc, fetch, exec, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (n_exec !== n0) begin
      miscompares++;
      $display("FAIL resetmid exec pulses got %0d want %0d",
               n_exec, n0);
    end
    w[0] = mk(0,0,0,0,0,0,0, 0,0,0,0,0);
    w[1] = mk(0,0,0,0,0,0,0, 0,0,0,0,0);
    w[2] = mk(1,0,0,0,0,0,0, 0,0,0,0,0);
    w[3] = mk(0,0,0,0,0,0,0, 0,1,0,1,0);
    for (int i = 0; i < 4; i++) begin
      apply(w[i], 1'b0);
      vectors++;
      if ({pc, fetch, exec, busy, done} !==
          {w[i].pc, w[i].f, w[i].e, w[i].y, w[i].d}) begin
        miscompares++;
        $display("FAIL afterreset[%0d] pc/fe/ex/bz/dn got %0d/%b%b%b%b want %0d/%b%b%b%b",
          i, pc, fetch, exec, busy, done,
          w[i].pc, w[i].f, w[i].e, w[i].y, w[i].d);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_program;
    test_rerun;
    test_memwait;
    test_branch;
    test_wrap4;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
